// File: rtl/sat_accumulator.sv
`timescale 1ns/1ps
// Reduces each group of up to LEN beats (or fewer, closed by last_i) to one saturated sum.
// Result is registered one cycle after the closing beat; in HOLD, input ready follows ready_i.
module sat_accumulator #(
  parameter  int DATAW = 32,
  parameter  int LEN   = 8,
  localparam int CNTW  = $clog2(LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DATAW-1:0] data_i,
  input  logic             last_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DATAW-1:0] sum_o,
  output logic [CNTW-1:0]  cnt_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam logic [CNTW-1:0]  LEN_C = CNTW'(LEN);
  localparam logic [DATAW-1:0] MAX_C = {1'b0, {(DATAW-1){1'b1}}};
  localparam logic [DATAW-1:0] MIN_C = {1'b1, {(DATAW-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [DATAW-1:0] acc;
  logic [CNTW-1:0]  cnt;
  logic             ovf;

  logic [DATAW-1:0] base, wsum, step;
  logic [CNTW-1:0]  cnt_inc;
  logic             pos_ovf, neg_ovf, ovf_nxt, closing, accept;

  always_comb begin
    base    = (cnt == '0) ? '0 : acc;
    wsum    = base + data_i;
    pos_ovf = !base[DATAW-1] && !data_i[DATAW-1] &&  wsum[DATAW-1];
    neg_ovf =  base[DATAW-1] &&  data_i[DATAW-1] && !wsum[DATAW-1];
    step    = pos_ovf ? MAX_C : (neg_ovf ? MIN_C : wsum);
    ovf_nxt = ((cnt == '0) ? 1'b0 : ovf) | pos_ovf | neg_ovf;
    cnt_inc = cnt + 1'b1;
    closing = last_i || (cnt_inc == LEN_C);
  end

  assign accept  = valid_i && ready_o;
  assign valid_o = (state == HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ACC;
    else       state <= state_nxt;
  end

  // A closing beat while the held result drains keeps us in HOLD for back-to-back results.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b1;
    case (state)
      ACC: begin
        if (accept && closing) state_nxt = HOLD;
      end
      HOLD: begin
        ready_o = ready_i;
        if (ready_i && !(accept && closing)) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      sum_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        sum_o <= step;
        cnt_o <= cnt_inc;
        ovf_o <= ovf_nxt;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        acc   <= step;
        cnt   <= cnt_inc;
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
`timescale 1ns/1ps
// Bench for sat_accumulator: directed scenarios on DATAW=8 with LEN=4 and LEN=1,
// then randomized traffic against a clamp-per-step group model.
module tb_sat_accumulator;

  localparam int W    = 8;
  localparam int LENA = 4;
  localparam int MAXV = 2**(W-1) - 1;
  localparam int MINV = -(2**(W-1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_data = '0, a_sum;
  logic         a_last = 1'b0, a_valid = 1'b0, a_rdy = 1'b1;
  logic         a_ready, a_ovf, a_valid_o;
  logic [2:0]   a_cnt;

  logic [W-1:0] b_data = '0, b_sum;
  logic         b_last = 1'b0, b_valid = 1'b0, b_rdy = 1'b1;
  logic         b_ready, b_ovf, b_valid_o;
  logic [0:0]   b_cnt;

  int vectors = 0;
  int miscompares = 0;

  sat_accumulator #(.DATAW(W), .LEN(LENA)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .last_i(a_last), .valid_i(a_valid),
    .ready_o(a_ready), .sum_o(a_sum), .cnt_o(a_cnt), .ovf_o(a_ovf),
    .valid_o(a_valid_o), .ready_i(a_rdy));

  sat_accumulator #(.DATAW(W), .LEN(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .last_i(b_last), .valid_i(b_valid),
    .ready_o(b_ready), .sum_o(b_sum), .cnt_o(b_cnt), .ovf_o(b_ovf),
    .valid_o(b_valid_o), .ready_i(b_rdy));

  task automatic a_beat(input int d, input bit last);
    a_valid = 1'b1;
    a_data  = W'(d);
    a_last  = last;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got a=%b b=%b expected 0", a_valid_o, b_valid_o); end
    vectors++; if (a_sum !== 8'd0 || a_cnt !== 3'd0 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_outputs: got sum=%0d cnt=%0d ovf=%b expected 0/0/0", a_sum, a_cnt, a_ovf); end
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_group();
    int d[4] = '{10, 20, 30, 40};
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_beat(d[i], 1'b0);
      if (i < 3) begin
        vectors++; if (a_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: beat %0d got %b expected 0", i, a_valid_o); end
      end
    end
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 100 || a_cnt !== 3'd4 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_result: got v=%b sum=%0d cnt=%0d ovf=%b expected 1/100/4/0", a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    @(posedge clk); #1;
    vectors++; if (a_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %b expected 0", a_valid_o); end
  endtask

  task automatic test_pos_saturation();
    int d[4] = '{100, 100, -50, 10};
    for (int i = 0; i < 4; i++) a_beat(d[i], 1'b0);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 87 || a_cnt !== 3'd4 || a_ovf !== 1'b1) begin miscompares++; $display("FAIL pos_sat: got v=%b sum=%0d cnt=%0d ovf=%b expected 1/87/4/1", a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_neg_saturation_last();
    a_beat(-100, 1'b0);
    a_beat(-100, 1'b1);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== -128 || a_cnt !== 3'd2 || a_ovf !== 1'b1) begin miscompares++; $display("FAIL neg_sat_last: got v=%b sum=%0d cnt=%0d ovf=%b expected 1/-128/2/1", a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) a_beat(i, 1'b0);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 10 || a_cnt !== 3'd4 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared: got v=%b sum=%0d cnt=%0d ovf=%b expected 1/10/4/0", a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) a_beat(10 * i, 1'b0);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 100) begin miscompares++; $display("FAIL bp_close: got v=%b sum=%0d expected 1/100", a_valid_o, $signed(a_sum)); end
    a_rdy = 1'b0; a_valid = 1'b1; a_data = 8'd7;
    #1;
    vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: got %b expected 0", a_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (a_ready !== 1'b0 || a_valid_o !== 1'b1 || $signed(a_sum) !== 100 || a_cnt !== 3'd4 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL bp_hold: cycle %0d got rdy=%b v=%b sum=%0d cnt=%0d ovf=%b expected 0/1/100/4/0", i, a_ready, a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    end
    a_rdy = 1'b1;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_follow: got %b expected 1", a_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    vectors++; if (a_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_consumed: got %b expected 0", a_valid_o); end
    for (int i = 1; i <= 3; i++) a_beat(i, 1'b0);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 13 || a_cnt !== 3'd4) begin miscompares++; $display("FAIL bp_new_group: got v=%b sum=%0d cnt=%0d expected 1/13/4", a_valid_o, $signed(a_sum), a_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int d[3] = '{5, -3, 7};
    b_rdy = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = W'(d[i]);
      @(posedge clk); #1;
      vectors++; if (b_valid_o !== 1'b1 || $signed(b_sum) !== d[i] || b_cnt !== 1'b1 || b_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b: beat %0d got v=%b sum=%0d cnt=%0d ovf=%b expected 1/%0d/1/0", i, b_valid_o, $signed(b_sum), b_cnt, b_ovf, d[i]); end
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (b_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", b_valid_o); end
  endtask

  task automatic test_reset_mid_group();
    a_beat(10, 1'b0);
    a_beat(20, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++; if (a_valid_o !== 1'b0 || a_sum !== 8'd0 || a_cnt !== 3'd0 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got v=%b sum=%0d cnt=%0d ovf=%b expected 0/0/0/0", a_valid_o, a_sum, a_cnt, a_ovf); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 1; i <= 4; i++) a_beat(i, 1'b0);
    vectors++; if (a_valid_o !== 1'b1 || $signed(a_sum) !== 10 || a_cnt !== 3'd4 || a_ovf !== 1'b0) begin miscompares++; $display("FAIL mid_reset_residue: got v=%b sum=%0d cnt=%0d ovf=%b expected 1/10/4/0", a_valid_o, $signed(a_sum), a_cnt, a_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int  grp[$];
    bit  m_hold = 1'b0;
    int  m_sum = 0;
    int  m_cnt = 0;
    bit  m_ovf = 1'b0;
    bit  exp_rdy, take;
    int  total;
    bit  o;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_last  = ($urandom_range(0, 4) == 0);
      a_rdy   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       a_data = W'($urandom);
        1:       a_data = W'($urandom_range(90, 127));
        default: a_data = W'(-$signed($urandom_range(90, 128)));
      endcase
      @(negedge clk);
      exp_rdy = m_hold ? a_rdy : 1'b1;
      vectors++; if (a_ready !== exp_rdy || a_valid_o !== m_hold) begin miscompares++; $display("FAIL rand_handshake: cycle %0d got rdy=%b v=%b expected %b/%b", cyc, a_ready, a_valid_o, exp_rdy, m_hold); end
      if (m_hold) begin
        vectors++; if ($signed(a_sum) !== m_sum || int'(a_cnt) != m_cnt || a_ovf !== m_ovf) begin miscompares++; $display("FAIL rand_result: cycle %0d got sum=%0d cnt=%0d ovf=%b expected %0d/%0d/%b", cyc, $signed(a_sum), a_cnt, a_ovf, m_sum, m_cnt, m_ovf); end
      end
      take = a_valid && exp_rdy;
      if (take) grp.push_back(int'($signed(a_data)));
      if (take && (a_last || grp.size() == LENA)) begin
        total = 0; o = 1'b0;
        foreach (grp[k]) begin
          total += grp[k];
          if (total > MAXV) begin total = MAXV; o = 1'b1; end
          else if (total < MINV) begin total = MINV; o = 1'b1; end
        end
        m_sum = total; m_cnt = grp.size(); m_ovf = o; m_hold = 1'b1;
        grp.delete();
      end else if (m_hold && a_rdy) begin
        m_hold = 1'b0;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0; a_last = 1'b0; a_rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_group();
    test_pos_saturation();
    test_neg_saturation_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
- Streaming saturating accumulator that sits directly downstream of the saturating adder stage.
- Consumes a valid/ready stream of DATAW-bit two's-complement values and reduces each group of LEN beats to one saturated sum. A group also closes early on last_i.
- Emits one result per group through a registered valid/ready output with full backpressure. Used for dot-product and row reductions after the adder.

Parameters:
- DATAW, 32, width of input data and result (two's complement).
- LEN, 8, maximum beats per group; must be >= 1. Counter width CNTW = $clog2(LEN+1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- data_i  input  DATAW  input value.
- last_i  input  1  closes the current group on this beat; qualified by valid_i.
- valid_i  input  1  input beat valid.
- ready_o  output  1  block can accept a beat.
- sum_o  output  DATAW  saturated group sum.
- cnt_o  output  CNTW  number of beats in the emitted group (1..LEN).
- ovf_o  output  1  at least one saturation event occurred in the emitted group (sticky per group).
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.

Behaviour:
- Reset, asynchronous on rst_i=1:
  - acc=0, cnt=0, ovf=0.
  - sum_o=0, cnt_o=0, ovf_o=0, valid_o=0.
  - The state machine goes to ACC.
  - Any partial group is discarded. Reset asserted mid-group or mid-hold loses that group with no output.
- Accept: a beat is accepted when valid_i && ready_o.
- Step arithmetic, computed on each accepted beat:
  - base = (cnt==0) ? 0 : acc.
  - s = base + data_i, with DATAW-bit wrap.
  - Positive overflow: base and data_i both non-negative and s negative. Result is {0,1...1}.
  - Negative overflow: base and data_i both negative and s non-negative. Result is {1,0...0}.
  - Otherwise the result is s.
  - Saturation is applied per step, not sticky on the value. A later beat of opposite sign moves the sum back off the rail.
- ovf: on each accepted beat, ovf_next = (cnt==0 ? 0 : ovf) | overflow_this_step.
- Group close: an accepted beat closes the group if last_i=1 or cnt+1==LEN. On the next edge:
  - sum_o, cnt_o and ovf_o are loaded with the step result, cnt+1 and ovf_next.
  - valid_o is set to 1.
  - cnt is set to 0.
- Non-closing beat: acc, cnt and ovf are updated; valid_o is unchanged.
- States:
  - ACC (valid_o=0): ready_o=1. A closing beat moves the FSM to HOLD.
  - HOLD (valid_o=1): ready_o=ready_i.
    - If ready_i=1, the result is consumed that cycle and a beat may be accepted in the same cycle, starting a new group (base=0).
    - HOLD with ready_i=1 and a closing beat accepted stays in HOLD with the new result loaded on the edge. This gives back-to-back results, e.g. LEN=1 at full throughput.
    - HOLD with ready_i=1 and no closing beat goes to ACC, with valid_o=0 next cycle.
    - HOLD with ready_i=0: ready_o=0, and sum_o, cnt_o, ovf_o and valid_o are held stable.
- Latency: the result appears 1 cycle after the closing beat is accepted. Throughput is 1 beat/cycle when ready_i=1.
- last_i on a beat where cnt+1==LEN closes the group only once; no empty group is generated.
- last_i while valid_i=0 is ignored.
- Input beats are only accepted in HOLD when ready_i=1. No internal skid buffer.
- ready_o depends combinationally on ready_i only in HOLD. There is no combinational path from valid_i to ready_o.
- Output-stability rule (verification assertion): while valid_o=1 and ready_i=0, sum_o, cnt_o and ovf_o must not change.

Test Plan:
1. DATAW=8, LEN=4; beats 10, 20, 30, 40 with ready_i=1 → one cycle after beat 4: valid_o=1, sum_o=100, cnt_o=4, ovf_o=0. No earlier valid_o.
2. Positive saturation: beats 100, 100, -50, 10 → step values 100, 127 (ovf), 77, 87. Output sum_o=87, ovf_o=1, cnt_o=4.
3. Negative saturation with last_i: beats -100, -100 (last_i=1) → sum_o=-128, cnt_o=2, ovf_o=1. The next group of 1, 2, 3, 4 gives sum_o=10 and ovf_o=0, so the flag is cleared between groups.
4. Backpressure: close a group (sum_o=100) and hold ready_i=0 for 5 cycles while valid_i=1 → ready_o=0 and the outputs stay stable. Raise ready_i → the result is consumed and the same-cycle beat starts a new group with base 0.
5. LEN=1, continuous valid_i and ready_i=1 with data 5, -3, 7 → valid_o stays high on 3 consecutive cycles with sum_o 5, -3, 7 and cnt_o=1.
6. Reset mid-group: after beats 10, 20, assert rst_i asynchronously → valid_o=0, sum_o=0 immediately. Then beats 1, 2, 3, 4 give sum_o=10, so no residue from the aborted group.
